// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single external memory bus shared by instruction fetch and data access
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   if_req, if_addr           fetch request and PC
//   if_inst                   registered fetched instruction
//   mem_req, mem_we,          load/store request from the MEM stage
//   mem_addr, mem_wdata,
//   mem_sel
//   mem_rdata                 registered load data
//   id_stallreq, ex_stallreq  decode / execute stall requests
//   stall                     pipeline stall vector {WB, MEM, EX, ID, IF, PC}
//   bus_req, bus_we,          registered bus command, held until bus_ack
//   bus_addr, bus_wdata,
//   bus_sel
//   bus_rdata, bus_ack        slave read data and one-cycle completion strobe

`timescale 1ns/1ps

module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_inst,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_sel,
    output logic [DATA_W-1:0]   mem_rdata,
    input  logic                id_stallreq,
    input  logic                ex_stallreq,
    output logic [5:0]          stall,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_sel,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_ack
);

    typedef enum logic [1:0] {
        IDLE,
        IF_BUSY,
        MEM_BUSY
    } state_t;

    state_t state;

    // A done flag marks that the stage's current request has already been
    // served; it stays set until the stage actually advances so the same
    // request is never issued twice while a later stage holds the pipeline.
    logic if_done;
    logic mem_done;
    logic if_pend;
    logic mem_pend;

    assign if_pend  = if_req && !if_done;
    assign mem_pend = mem_req && !mem_done;

    // The oldest stalling stage wins; everything upstream of it is frozen.
    always_comb begin
        stall = 6'b000000;
        if (mem_pend) begin
            stall = 6'b011111;
        end else if (ex_stallreq) begin
            stall = 6'b001111;
        end else if (id_stallreq) begin
            stall = 6'b000111;
        end else if (if_pend) begin
            stall = 6'b000011;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_sel   <= '0;
            if_inst   <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            // Clears come first so that a completion on the same edge wins.
            if (!stall[1]) begin
                if_done <= 1'b0;
            end
            if (!stall[4]) begin
                mem_done <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // MEM belongs to the older instruction, so it goes first.
                    if (mem_pend) begin
                        bus_req   <= 1'b1;
                        bus_we    <= mem_we;
                        bus_addr  <= mem_addr;
                        bus_wdata <= mem_wdata;
                        bus_sel   <= mem_sel;
                        state     <= MEM_BUSY;
                    end else if (if_pend) begin
                        bus_req  <= 1'b1;
                        bus_we   <= 1'b0;
                        bus_addr <= if_addr;
                        bus_sel  <= '1;
                        state    <= IF_BUSY;
                    end
                end
                IF_BUSY: begin
                    if (bus_ack) begin
                        if_inst <= bus_rdata;
                        if_done <= 1'b1;
                        bus_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                MEM_BUSY: begin
                    if (bus_ack) begin
                        if (!bus_we) begin
                            mem_rdata <= bus_rdata;
                        end
                        mem_done <= 1'b1;
                        bus_req  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
